// File: rtl/biss_pkg.sv
// Shared constants and state type for the BiSS-C slave emulator.
package biss_pkg;

  localparam int CRC_W = 6;
  localparam logic [CRC_W-1:0] CRC_POLY = 6'h03;
  localparam int CDS_BITS = 1;
  localparam int STATUS_BITS = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_START,
    S_CDS,
    S_DATA,
    S_CRC,
    S_TIMEOUT
  } biss_slv_state_t;

endpackage

// File: rtl/biss_slave_emu_if.sv
// MA/SLO line pair between a BiSS master and the slave emulator.
interface biss_slave_emu_if;
  logic ma;
  logic slo;

  modport master (output ma, input slo);
  modport slave (input ma, output slo);
endinterface

// File: rtl/biss_crc6_ser.sv
// Bit-serial CRC6 (x^6+x+1), MSB-first, cleared to zero at frame start.
module biss_crc6_ser
  import biss_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/biss_slave_emu.sv
// BiSS-C single-cycle-data slave emulator: answers an external MA clock on SLO.
// Define BISS_SLAVE_MT_EN to send a multiturn field ahead of the position.
module biss_slave_emu
  import biss_pkg::*;
#(
  parameter int POS_BITS     = 24,
  parameter int ACK_CYCLES   = 2,
  parameter int TIMEOUT_CLKS = 400,
  parameter int MT_BITS      = 12
) (
  input  logic                clk,
  input  logic                rst,
  biss_slave_emu_if.slave     bus,
  input  logic [POS_BITS-1:0] position,
`ifdef BISS_SLAVE_MT_EN
  input  logic [MT_BITS-1:0]  mt_count,
`endif
  input  logic                err_n,
  input  logic                warn_n,
  output logic                busy,
  output logic                frame_done,
  output logic                cdm_bit,
  output logic                cdm_valid
);

`ifdef BISS_SLAVE_MT_EN
  localparam bit MT_EN = 1'b1;
`else
  localparam bit MT_EN = 1'b0;
`endif
  localparam int DATA_LEN = (MT_EN ? MT_BITS : 0) + POS_BITS + STATUS_BITS;
  localparam int CNT_W    = $clog2(DATA_LEN + ACK_CYCLES + CRC_W + CDS_BITS);
  localparam int TC_W     = $clog2(TIMEOUT_CLKS);
  localparam logic [TC_W-1:0] TC_MAX = TC_W'(TIMEOUT_CLKS - 1);

  biss_slv_state_t state, state_nxt;
  logic ma_meta, ma_s, ma_prev;
  logic ma_rise, ma_fall, ma_edge, timeout, in_frame;
  logic last_ack, last_data, last_crc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TC_W-1:0] tcnt;
  logic [DATA_LEN-1:0] data_sr, load_word;
  logic [CRC_W-1:0] crc;
  logic [2:0] crc_idx;
  logic load, shift;
  logic slo_q, slo_nxt, busy_nxt, frame_done_nxt, cdm_bit_nxt, cdm_valid_nxt;

`ifdef BISS_SLAVE_MT_EN
  assign load_word = {mt_count, position, err_n, warn_n};
`else
  assign load_word = {position, err_n, warn_n};
`endif

  // MA is asynchronous; idle line is high so the synchroniser resets high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ma_meta <= 1'b1;
      ma_s    <= 1'b1;
      ma_prev <= 1'b1;
    end else begin
      ma_meta <= bus.ma;
      ma_s    <= ma_meta;
      ma_prev <= ma_s;
    end
  end

  assign ma_rise   = ma_s & ~ma_prev;
  assign ma_fall   = ~ma_s & ma_prev;
  assign ma_edge   = ma_s ^ ma_prev;
  assign timeout   = (tcnt == TC_MAX) && !ma_edge;
  assign in_frame  = state inside {S_ACK, S_START, S_CDS, S_DATA, S_CRC};
  assign last_ack  = (cnt == CNT_W'(ACK_CYCLES - 1));
  assign last_data = (cnt == CNT_W'(DATA_LEN - 1));
  assign last_crc  = (cnt == CNT_W'(CRC_W - 1));
  assign crc_idx   = 3'(CRC_W - 1) - cnt[2:0];
  assign bus.slo   = slo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_sr <= '0;
      tcnt    <= '0;
    end else begin
      if (load) begin
        data_sr <= load_word;
      end else if (shift) begin
        data_sr <= {data_sr[DATA_LEN-2:0], 1'b0};
      end
      if (state == S_IDLE || ma_edge) begin
        tcnt <= '0;
      end else if (tcnt != TC_MAX) begin
        tcnt <= tcnt + TC_W'(1);
      end
    end
  end

  biss_crc6_ser u_crc (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (shift),
    .din (data_sr[DATA_LEN-1]),
    .crc (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      slo_q      <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cdm_bit    <= 1'b0;
      cdm_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      slo_q      <= slo_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      cdm_bit    <= cdm_bit_nxt;
      cdm_valid  <= cdm_valid_nxt;
    end
  end

  // Frame states only advance on MA rises; a silent MA mid-frame aborts to IDLE.
  always_comb begin
    state_nxt = state;
    if (in_frame && timeout) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (ma_fall) state_nxt = S_ACK;
        S_ACK:     if (ma_rise && last_ack) state_nxt = S_START;
        S_START:   if (ma_rise) state_nxt = S_CDS;
        S_CDS:     if (ma_rise) state_nxt = S_DATA;
        S_DATA:    if (ma_rise && last_data) state_nxt = S_CRC;
        S_CRC:     if (ma_rise && last_crc) state_nxt = S_TIMEOUT;
        S_TIMEOUT: if (timeout) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt        = cnt;
    slo_nxt        = slo_q;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    cdm_bit_nxt    = cdm_bit;
    cdm_valid_nxt  = 1'b0;
    load           = 1'b0;
    shift          = 1'b0;
    if (in_frame && timeout) begin
      slo_nxt  = 1'b1;
      busy_nxt = 1'b0;
      cnt_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          slo_nxt = 1'b1;
          if (ma_fall) begin
            load     = 1'b1;
            busy_nxt = 1'b1;
            cnt_nxt  = '0;
          end
        end
        S_ACK: if (ma_rise) begin
          slo_nxt = 1'b0;
          cnt_nxt = last_ack ? '0 : cnt + CNT_W'(1);
        end
        S_START: if (ma_rise) slo_nxt = 1'b1;
        S_CDS: if (ma_rise) begin
          slo_nxt = 1'b0;
          cnt_nxt = '0;
        end
        S_DATA: if (ma_rise) begin
          slo_nxt = data_sr[DATA_LEN-1];
          shift   = 1'b1;
          cnt_nxt = last_data ? '0 : cnt + CNT_W'(1);
        end
        S_CRC: if (ma_rise) begin
          slo_nxt        = ~crc[crc_idx];
          frame_done_nxt = last_crc;
          cnt_nxt        = last_crc ? '0 : cnt + CNT_W'(1);
        end
        S_TIMEOUT: begin
          if (timeout) begin
            cdm_bit_nxt   = ~ma_s;
            cdm_valid_nxt = 1'b1;
            slo_nxt       = 1'b1;
            busy_nxt      = 1'b0;
          end else if (ma_rise) begin
            slo_nxt = 1'b0;
          end
        end
        default: begin
          slo_nxt  = 1'b1;
          busy_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biss_slave_emu.sv
// Directed self-checking bench for biss_slave_emu: drives MA at 2.5 MHz and decodes SLO.
module tb_biss_slave_emu;

  localparam int POS_BITS     = 24;
  localparam int TIMEOUT_CLKS = 400;
`ifdef BISS_SLAVE_MT_EN
  localparam int DL = 12 + POS_BITS + 2;
`else
  localparam int DL = POS_BITS + 2;
`endif
  localparam int NR = 4 + DL + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ma = 1'b1;
  logic [POS_BITS-1:0] position = '0;
  logic err_n = 1'b0;
  logic warn_n = 1'b0;
`ifdef BISS_SLAVE_MT_EN
  logic [11:0] mt_count = '0;
`endif
  logic slo, busy, frame_done, cdm_bit, cdm_valid;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;
  int cv_cnt = 0;
  int fd0, cv0;
  logic bits [0:63];
  logic pre_bits [0:63];
  logic [63:0] exp_word;
  logic [5:0] crc_obs, crc_exp;

  biss_slave_emu_if bus ();
  assign bus.ma = ma;
  assign slo = bus.slo;

  biss_slave_emu #(
    .POS_BITS     (POS_BITS),
    .ACK_CYCLES   (2),
    .TIMEOUT_CLKS (TIMEOUT_CLKS),
    .MT_BITS      (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .position   (position),
`ifdef BISS_SLAVE_MT_EN
    .mt_count   (mt_count),
`endif
    .err_n      (err_n),
    .warn_n     (warn_n),
    .busy       (busy),
    .frame_done (frame_done),
    .cdm_bit    (cdm_bit),
    .cdm_valid  (cdm_valid)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (cdm_valid) cv_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame of MA: a falling edge starts it, then n_rise 20-clk periods.
  task automatic applyStimulus(input int n_rise, input bit end_low);
    if (!ma) begin
      ma = 1'b1;
      repeat (10) @(negedge clk);
    end
    ma = 1'b0;
    for (int i = 0; i < n_rise; i++) begin
      repeat (10) @(negedge clk);
      ma = 1'b1;
      repeat (2) @(negedge clk);
      pre_bits[i] = slo;
      @(negedge clk);
      bits[i] = slo;
      repeat (7) @(negedge clk);
      if (i != n_rise - 1 || end_low) ma = 1'b0;
    end
  endtask

  function automatic logic [63:0] field(input int start, input int len);
    logic [63:0] w = '0;
    for (int i = 0; i < len; i++) w = {w[62:0], bits[start+i]};
    return w;
  endfunction

  // Remainder of message*x^6 divided by x^6+x+1, inverted.
  function automatic logic [5:0] crc_model(input logic [63:0] w, input int n);
    logic [69:0] r;
    r = 70'(w) << 6;
    for (int i = n + 5; i >= 6; i--)
      if (r[i]) r[i -: 7] = r[i -: 7] ^ 7'h43;
    return ~r[5:0];
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_outs", 64'({slo, busy, frame_done, cdm_bit, cdm_valid}), 64'(5'b10000));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] frame A5A5A5, inputs changed mid-frame, MA left low");
    position = 24'hA5A5A5; err_n = 1'b1; warn_n = 1'b1;
    fd0 = fd_cnt; cv0 = cv_cnt;
    fork
      applyStimulus(NR, 1'b1);
      begin
        repeat (60) @(negedge clk);
        position = 24'h5A5A5A; err_n = 1'b0; warn_n = 1'b0;
      end
    join
    checkOutput("slo_before_3clk", 64'(pre_bits[0]), 64'(1));
    checkOutput("ack_bits", 64'({bits[0], bits[1]}), 64'(2'b00));
    checkOutput("start_cds", 64'({bits[2], bits[3]}), 64'(2'b10));
    exp_word = 64'({24'hA5A5A5, 2'b11});
    checkOutput("a5_data", field(4, DL), exp_word);
    crc_obs = field(4 + DL, 6)[5:0];
    crc_exp = crc_model(exp_word, DL);
    checkOutput("a5_crc", 64'(crc_obs), 64'(crc_exp));
    checkOutput("a5_corrupt_seen", 64'(crc_obs != (crc_exp ^ 6'h04)), 64'(1));
    repeat (500) @(negedge clk);
    checkOutput("a5_frame_done", 64'(fd_cnt - fd0), 64'(1));
    checkOutput("cdm_low_valid", 64'(cv_cnt - cv0), 64'(1));
    checkOutput("cdm_low_bit", 64'(cdm_bit), 64'(1));
    checkOutput("cdm_low_idle", 64'({slo, busy}), 64'(2'b10));

    $display("[TB] all-zero frame plus 4 timeout rises, MA left high");
    position = '0; err_n = 1'b0; warn_n = 1'b0;
    fd0 = fd_cnt; cv0 = cv_cnt;
    applyStimulus(NR + 4, 1'b0);
    checkOutput("zero_hdr", 64'({bits[0], bits[1], bits[2], bits[3]}), 64'(4'b0010));
    checkOutput("zero_data", field(4, DL), 64'(0));
    checkOutput("zero_crc", field(4 + DL, 6), 64'(6'h3F));
    checkOutput("zero_timeout_slo", field(NR, 4), 64'(0));
    checkOutput("zero_in_timeout", 64'({slo, busy}), 64'(2'b01));
    repeat (490) @(negedge clk);
    checkOutput("zero_frame_done", 64'(fd_cnt - fd0), 64'(1));
    checkOutput("cdm_high_valid", 64'(cv_cnt - cv0), 64'(1));
    checkOutput("cdm_high_bit", 64'(cdm_bit), 64'(0));
    checkOutput("cdm_high_idle", 64'({slo, busy}), 64'(2'b10));

    $display("[TB] MA stopped after 10th data bit");
    position = 24'hA5A5A5; err_n = 1'b1; warn_n = 1'b1;
    fd0 = fd_cnt; cv0 = cv_cnt;
    applyStimulus(14, 1'b0);
    repeat (392) @(negedge clk);
    checkOutput("abort_before", 64'(busy), 64'(1));
    @(negedge clk);
    checkOutput("abort_at", 64'({slo, busy}), 64'(2'b10));
    repeat (100) @(negedge clk);
    checkOutput("abort_no_done", 64'(fd_cnt - fd0), 64'(0));
    checkOutput("abort_no_cdm", 64'(cv_cnt - cv0), 64'(0));

    $display("[TB] reset asserted in DATA, then a fresh frame");
    applyStimulus(8, 1'b0);
    checkOutput("data_bit4_slo", 64'(slo), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_frame", 64'({slo, busy}), 64'(2'b10));
    rst = 1'b0;
    position = 24'h3C0F81; err_n = 1'b1; warn_n = 1'b0;
    repeat (5) @(negedge clk);
    fd0 = fd_cnt;
    applyStimulus(NR, 1'b0);
    exp_word = 64'({24'h3C0F81, 2'b10});
    checkOutput("post_rst_data", field(4, DL), exp_word);
    checkOutput("post_rst_crc", field(4 + DL, 6), 64'(crc_model(exp_word, DL)));
    repeat (500) @(negedge clk);
    checkOutput("post_rst_done", 64'(fd_cnt - fd0), 64'(1));

`ifdef BISS_SLAVE_MT_EN
    $display("[TB] multiturn frame");
    mt_count = 12'h123; position = 24'h000001; err_n = 1'b1; warn_n = 1'b0;
    applyStimulus(NR, 1'b0);
    exp_word = 64'({12'h123, 24'h000001, 2'b10});
    checkOutput("mt_first", field(4, 12), 64'(12'h123));
    checkOutput("mt_data", field(4, DL), exp_word);
    checkOutput("mt_crc", field(4 + DL, 6), 64'(crc_model(exp_word, DL)));
    repeat (500) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
